// File: rtl/rr_arb_pkg.sv
// Shared types and the rotate-and-encode helper for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First requester at or after ptr, wrapping modulo N_REQ.
  function automatic logic [ID_W-1:0] rot_first(input logic [N_REQ-1:0] req,
                                                input logic [ID_W-1:0]  ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [ID_W-1:0]    off;
    dbl = {req, req} >> ptr;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (dbl[i]) off = ID_W'(i);
    end
    return off + ptr;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: rotate req by ptr, lowest-index priority encode, un-rotate.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  assign any = |req;
  assign idx = rot_first(req, ptr);

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant, binary id and optional hold timeout.
// One idle cycle always separates consecutive grants so the shared resource can turn around.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int CNT_W = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam bit TO_EN = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [ID_W-1:0]  id_nxt;
  logic             to_nxt;
  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;
  logic             rel_a, rel_b;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign rel_a     = ~req[gnt_id];
  assign rel_b     = TO_EN && (hold_cnt == HOLD_LAST);
  assign gnt_valid = |gnt;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    ptr_nxt   = ptr;
    cnt_nxt   = hold_cnt;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          gnt_nxt   = N_REQ'(1) << pick_idx;
          id_nxt    = pick_idx;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (rel_a || rel_b) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = gnt_id + ID_W'(1);
          // An owner dropping its request on the final cycle is a normal release.
          to_nxt    = ~rel_a;
        end else begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= id_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= cnt_nxt;
      timeout  <= to_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench: three arbiter instances (HOLD_MAX 16, 4, 3) driven by one linear sequence.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst16 = 1'b1, rst4 = 1'b1, rst3 = 1'b1;
  logic [7:0] req16 = 8'hFF, req4 = 8'h00, req3 = 8'h00;
  logic [7:0] gnt16, gnt4, gnt3;
  logic [2:0] id16, id4, id3;
  logic       vld16, vld4, vld3;
  logic       to16, to4, to3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.HOLD_MAX(16)) dut16 (
    .clk(clk), .rst(rst16), .req(req16), .gnt(gnt16),
    .gnt_id(id16), .gnt_valid(vld16), .timeout(to16)
  );
  rr_arbiter8 #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst(rst4), .req(req4), .gnt(gnt4),
    .gnt_id(id4), .gnt_valid(vld4), .timeout(to4)
  );
  rr_arbiter8 #(.HOLD_MAX(3)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .gnt(gnt3),
    .gnt_id(id3), .gnt_valid(vld3), .timeout(to3)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [7:0] g, input logic [2:0] id,
                       input logic v, input logic t);
    chk({tag, ".gnt"}, gnt16, g);
    chk({tag, ".id"}, {5'd0, id16}, {5'd0, id});
    chk({tag, ".vld"}, {7'd0, vld16}, {7'd0, v});
    chk({tag, ".to"}, {7'd0, to16}, {7'd0, t});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three edges with every requester active.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk16("rst_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    end
    chk("rst4.gnt", gnt4, 8'h00);
    chk("rst3.gnt", gnt3, 8'h00);
    rst16 = 1'b0; rst4 = 1'b0; rst3 = 1'b0;
    tick();
    chk16("rst_release", 8'h01, 3'd0, 1'b1, 1'b0);

    // Reset again mid-grant: drop without timeout.
    rst16 = 1'b1; req16 = 8'h00;
    tick();
    chk16("rst_drop", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single owner for five cycles, then release leaves ptr at 3.
    rst16 = 1'b0; req16 = 8'h04;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk16("single", 8'h04, 3'd2, 1'b1, 1'b0);
    end
    req16 = 8'h00;
    tick();
    chk16("single_rel", 8'h00, 3'd2, 1'b0, 1'b0);

    // All request: ptr=3 picks 3; non-owners ignored; 16-cycle timeout.
    req16 = 8'hFF;
    tick();
    chk16("ptr3", 8'h08, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk16("hold16", 8'h08, 3'd3, 1'b1, 1'b0);
    end
    tick();
    chk16("to16", 8'h00, 3'd3, 1'b0, 1'b1);
    tick();
    chk16("after_to16", 8'h10, 3'd4, 1'b1, 1'b0);
    req16 = 8'h00;
    tick();
    chk16("rel4", 8'h00, 3'd4, 1'b0, 1'b0);

    // Serve 5, leaving ptr=6; then 0 wins over 5 by wrap-around.
    req16 = 8'h20;
    tick();
    chk16("serve5", 8'h20, 3'd5, 1'b1, 1'b0);
    req16 = 8'h00;
    tick();
    chk16("rel5", 8'h00, 3'd5, 1'b0, 1'b0);
    req16 = 8'h21;
    tick();
    chk16("wrap0", 8'h01, 3'd0, 1'b1, 1'b0);
    req16 = 8'h20;
    tick();
    chk16("wrap_rel0", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk16("wrap5", 8'h20, 3'd5, 1'b1, 1'b0);

    // Mid-grant reset on a grant to 3, then a fresh grant to 3.
    req16 = 8'h00;
    tick();
    chk16("rel5b", 8'h00, 3'd5, 1'b0, 1'b0);
    req16 = 8'h08;
    tick();
    chk16("g3_c1", 8'h08, 3'd3, 1'b1, 1'b0);
    tick();
    chk16("g3_c2", 8'h08, 3'd3, 1'b1, 1'b0);
    rst16 = 1'b1;
    tick();
    chk16("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst16 = 1'b0;
    tick();
    chk16("fresh3", 8'h08, 3'd3, 1'b1, 1'b0);

    // HOLD_MAX=4 rotation: 4-cycle grants, idle cycle carries the timeout pulse.
    req4 = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("rot.gnt", gnt4, 8'(1) << (g % 8));
        chk("rot.id", {5'd0, id4}, 8'(g % 8));
        chk("rot.to", {7'd0, to4}, 8'h00);
      end
      tick();
      chk("rot_idle.gnt", gnt4, 8'h00);
      chk("rot_idle.to", {7'd0, to4}, 8'h01);
    end
    req4 = 8'h00;

    // HOLD_MAX=3: owner drops on the third grant cycle -> no timeout.
    req3 = 8'h04;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("sim.gnt", gnt3, 8'h04);
    end
    req3 = 8'h00;
    tick();
    chk("sim_rel.gnt", gnt3, 8'h00);
    chk("sim_rel.to", {7'd0, to3}, 8'h00);
    chk("sim_rel.vld", {7'd0, vld3}, 8'h00);

    // Same owner keeps requesting -> timeout after three cycles, then re-granted.
    req3 = 8'h04;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("to3.gnt", gnt3, 8'h04);
      chk("to3.id", {5'd0, id3}, 8'h02);
    end
    tick();
    chk("to3_rel.gnt", gnt3, 8'h00);
    chk("to3_rel.to", {7'd0, to3}, 8'h01);
    tick();
    chk("to3_again.gnt", gnt3, 8'h04);
    chk("to3_again.to", {7'd0, to3}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Built around the team's 8-to-3 encoding datapath: it turns a request vector into a registered one-hot grant plus its 3-bit binary index.
- Sits between requester blocks and a shared resource such as a bus, memory port or encoder output channel.
- Grants are held until the owner drops its request, or until an optional hold-timeout forces release.

Parameters:
- HOLD_MAX, 16: maximum consecutive grant cycles per owner. 0 disables the timeout.
- CNT_W, derived: max(1, $clog2(HOLD_MAX+1)). Width of the hold counter. Not user-set.

Ports:
- clk, input, 1: single clock. All state is updated on the rising edge.
- rst, input, 1: synchronous, active-high reset. Sampled on the rising edge of clk.
- req, input, 8: request vector. req[i]=1 means requester i wants the resource.
- gnt, output, 8: one-hot grant, registered. Value 0 means no owner.
- gnt_id, output, 3: binary index of the current owner. Equals the 8-to-3 encoding of gnt.
- gnt_valid, output, 1: 1 when gnt is non-zero.
- timeout, output, 1: one-cycle pulse when a grant is force-released by HOLD_MAX.

Behaviour:
- Reset (rst=1 at a clock edge): gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, state=IDLE, hold_cnt=0. Reset overrides every other condition, including in the middle of a grant. A grant in progress is dropped on the next edge with no timeout pulse.
- ptr is 3 bits and holds the highest-priority index for the next arbitration.
- State IDLE:
  - If req==0: stay in IDLE and keep all outputs at 0.
  - Otherwise select winner w = the first index i with req[i]=1, scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
  - Next edge: gnt=1<<w, gnt_id=w, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req assertion to gnt is 1 cycle.
- State GRANT:
  - Release condition A: req[gnt_id]==0 at the edge.
  - Release condition B: HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1 at the edge.
  - On release: gnt=0, gnt_valid=0, ptr=gnt_id+1 (wraps 7 to 0), state=IDLE. gnt_id keeps its last value.
  - On release via B only: timeout=1 for that one cycle.
  - If neither condition holds: hold_cnt increments and gnt is unchanged.
- There is always exactly one idle cycle (gnt==0) between consecutive grants. This is the resource turnaround cycle.
- Requests from non-owners during GRANT are ignored and have no effect on gnt.
- Simultaneous events: if A and B are both true on the same edge, the release counts as A and timeout stays 0.
- Invariants:
  - gnt is always 0 or one-hot.
  - gnt_valid == |gnt.
  - While gnt_valid=1, gnt_id equals the encoding of gnt.
- HOLD_MAX=1: every grant lasts exactly one cycle. Timeout fires whenever the owner still requests at that edge.

Decomposition:
- Package rr_arb_pkg:
  - N_REQ=8, ID_W=3.
  - State enum {IDLE, GRANT}.
  - Function rot_first(req, ptr) returning a 3-bit index.
- Sub-module rr_pick8, purely combinational:
  - Inputs req[7:0] and ptr[2:0]. Outputs any and idx[2:0].
  - Implementation: rotate req right by ptr, 8-to-3 priority-encode with the lowest index winning, then add ptr mod 8.
  - Instantiated once. The top level holds the FSM, counter and output registers.

Test Plan:
- Reset behaviour: hold req=8'hFF with rst=1 for 3 cycles, then release rst → gnt=0 during reset. One cycle after release, gnt=8'h01, gnt_id=0.
- Single owner release: after reset, req=8'b0000_0100 for 5 cycles, then 0 → gnt=8'h04 for cycles 2–6 and gnt_id=2. Then gnt=0 and ptr=3.
- Rotation: req=8'hFF held with HOLD_MAX=4 → grants go 0,1,2,…,7,0. Each grant is 4 cycles followed by 1 idle cycle, with a timeout pulse at the end of every grant.
- Wrap-around: ptr=6 (after serving 5), then req=8'b0010_0001 → grant goes to 0, not 5. Next grant goes to 5.
- Simultaneous release: HOLD_MAX=3; the owner drops req on exactly the third grant cycle → release happens with timeout=0.
- Mid-grant reset: assert rst during cycle 2 of a grant to id=3 → gnt=0 on the next edge, ptr=0, no timeout pulse. Then req=8'h08 produces a fresh grant to 3.
